instruction_fetch_unit: RTL and testbench

Instruction source for `cpu`: holds a loadable machine-code store and streams it, in program order, onto the `current_instruction` interface that `cpu` consumes. It is the producer end of that interface. A loader (bench or host) fills the store through a write port, then pulses `start`. The unit sequences a program counter, honours a consumer stall, and flags completion.

---
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - loadable instruction store streamed in program order to the cpu
module instruction_fetch_unit #(
  parameter int INSTRUCTION_WIDTH       = 32,
  parameter int MAX_MACHINE_CODE_LENGTH = 64,
  parameter int ADDRESS_WIDTH           = $clog2(MAX_MACHINE_CODE_LENGTH)
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic                         load_enable,
  input  logic [ADDRESS_WIDTH-1:0]     load_address,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data,
  output logic                         load_rejected,
  input  logic [ADDRESS_WIDTH:0]       program_length,
  input  logic                         start,
  input  logic                         stall,
  output logic [INSTRUCTION_WIDTH-1:0] current_instruction,
  output logic                         instruction_valid,
  output logic [ADDRESS_WIDTH:0]       program_counter,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DONE} state_e;

  localparam logic [ADDRESS_WIDTH:0] DEPTH = (ADDRESS_WIDTH+1)'(MAX_MACHINE_CODE_LENGTH);

  state_e                         state_q, state_d;
  logic [ADDRESS_WIDTH:0]         len_q, len_d;
  logic [ADDRESS_WIDTH:0]         pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
  logic                           valid_q, valid_d;
  logic                           rej_q, rej_d;
  logic [INSTRUCTION_WIDTH-1:0]   mem_q [MAX_MACHINE_CODE_LENGTH];
  logic [ADDRESS_WIDTH:0]         clamped_len;
  logic                           consumed;

  always_comb begin
    clamped_len = (program_length > DEPTH) ? DEPTH : program_length;
    consumed    = valid_q && !stall;
    state_d     = state_q;
    len_d       = len_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    rej_d       = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d   = clamped_len;
          pc_d    = '0;
          instr_d = '0;
          valid_d = 1'b0;
          state_d = (clamped_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        rej_d = load_enable;
        // A stalled, presented word blocks the pipeline; otherwise advance or finish.
        if (!valid_q || consumed) begin
          if (pc_q < len_q) begin
            instr_d = mem_q[pc_q[ADDRESS_WIDTH-1:0]];
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
          end else begin
            instr_d = '0;
            valid_d = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      rej_q   <= rej_d;
    end
  end

  // Store contents survive reset so a program can be re-run without reloading.
  always_ff @(posedge clock_in) begin
    if (load_enable && state_q != S_FETCH) begin
      mem_q[load_address] <= load_data;
    end
  end

  assign current_instruction = instr_q;
  assign instruction_valid   = valid_q;
  assign program_counter     = pc_q;
  assign load_rejected       = rej_q;
  assign busy                = (state_q == S_FETCH);
  assign done                = (state_q == S_DONE);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_enable;
  logic [5:0]  load_address;
  logic [31:0] load_data;
  logic        load_rejected;
  logic [6:0]  program_length;
  logic        start;
  logic        stall;
  logic [31:0] current_instruction;
  logic        instruction_valid;
  logic [6:0]  program_counter;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clock_in            (clk),
    .reset_in            (rst),
    .load_enable         (load_enable),
    .load_address        (load_address),
    .load_data           (load_data),
    .load_rejected       (load_rejected),
    .program_length      (program_length),
    .start               (start),
    .stall               (stall),
    .current_instruction (current_instruction),
    .instruction_valid   (instruction_valid),
    .program_counter     (program_counter),
    .busy                (busy),
    .done                (done)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    load_enable  = 1'b1;
    load_address = a;
    load_data    = d;
    cyc();
    load_enable  = 1'b0;
  endtask

  task automatic kick(input logic [6:0] len);
    program_length = len;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] w, input logic [6:0] pc);
    chk({tag, "_instr"}, 64'(current_instruction), 64'(w));
    chk({tag, "_valid"}, 64'(instruction_valid), 64'd1);
    chk({tag, "_pc"}, 64'(program_counter), 64'(pc));
  endtask

  task automatic chk_done(input string tag, input logic [6:0] pc);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_valid"}, 64'(instruction_valid), 64'd0);
    chk({tag, "_instr"}, 64'(current_instruction), 64'd0);
    chk({tag, "_pc"}, 64'(program_counter), 64'(pc));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_instr"}, 64'(current_instruction), 64'd0);
    chk({tag, "_valid"}, 64'(instruction_valid), 64'd0);
    chk({tag, "_pc"}, 64'(program_counter), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_rej"}, 64'(load_rejected), 64'd0);
  endtask

  initial begin
    logic [31:0] words [6];
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    words[3] = 32'h44444444;
    words[4] = 32'h55555555;
    words[5] = 32'h66666666;

    rst = 1'b1; load_enable = 1'b0; load_address = '0; load_data = '0;
    program_length = '0; start = 1'b0; stall = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk_reset("reset");

    for (int i = 0; i < 6; i++) load(6'(i), words[i]);
    chk("idle_after_load_busy", 64'(busy), 64'd0);

    // Plain 4-word run, no stall
    kick(7'd4);
    chk("run1_busy", 64'(busy), 64'd1);
    chk("run1_pre_valid", 64'(instruction_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk_word("run1_w", words[k], 7'(k + 1));
    end
    cyc();
    chk_done("run1_end", 7'd4);

    // Stall holds word 1 for four cycles total
    kick(7'd4);
    cyc();
    chk_word("st_w0", words[0], 7'd1);
    cyc();
    chk_word("st_w1", words[1], 7'd2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_word("st_hold", words[1], 7'd2);
    end
    stall = 1'b0;
    cyc();
    chk_word("st_w2", words[2], 7'd3);
    cyc();
    chk_word("st_w3", words[3], 7'd4);
    cyc();
    chk_done("st_end", 7'd4);

    // Zero length goes straight to DONE from IDLE
    rst = 1'b1; cyc(); rst = 1'b0;
    chk_reset("z_reset");
    kick(7'd0);
    chk_done("z_end", 7'd0);
    cyc();
    chk("z_valid_later", 64'(instruction_valid), 64'd0);

    // Write during FETCH is dropped and flagged
    kick(7'd4);
    load_enable = 1'b1; load_address = 6'd5; load_data = 32'hDEADBEEF;
    cyc();
    load_enable = 1'b0;
    chk("rej_pulse", 64'(load_rejected), 64'd1);
    chk_word("rej_w0", words[0], 7'd1);
    cyc();
    chk("rej_clear", 64'(load_rejected), 64'd0);
    cyc(); cyc(); cyc();
    chk_done("rej_end", 7'd4);
    kick(7'd6);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk_word("len6_w", words[k], 7'(k + 1));
    end
    cyc();
    chk_done("len6_end", 7'd6);

    // Reset mid-run, then re-run with store intact
    kick(7'd4);
    cyc();
    cyc();
    chk_word("mid_w1", words[1], 7'd2);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk_reset("mid_reset");
    kick(7'd4);
    cyc();
    chk_word("mid_rerun_w0", words[0], 7'd1);
    cyc(); cyc(); cyc(); cyc();
    chk_done("mid_rerun_end", 7'd4);

    // Oversized length clamps to depth; early stall does not block first fetch
    for (int i = 0; i < 64; i++) load(6'(i), 32'(32'hA000_0000 + i));
    kick(7'd100);
    stall = 1'b1;
    cyc();
    stall = 1'b0;
    chk_word("clamp_w0", 32'hA000_0000, 7'd1);
    for (int k = 1; k < 64; k++) begin
      cyc();
      chk("clamp_w", 64'(current_instruction), 64'(32'hA000_0000 + k));
    end
    chk("clamp_pc_last", 64'(program_counter), 64'd64);
    cyc();
    chk_done("clamp_end", 7'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
